// File: rtl/pulse_train_generator.sv
// pulse_train_generator: registered pulse-train transmitter.
// A burst is `count` high pulses, each `width` cycles long, separated by `gap`
// low cycles. start/busy/done form the handshake: start is taken only while
// idle, and the done strobe marks the end of the burst.
// Optional feature macro: PULSE_GEN_ABORT_EN adds the abort input and the
// aborted strobe. With it undefined, a burst ends only on completion or rst.
module pulse_train_generator #(
  parameter int W_WIDTH = 4,
  parameter int C_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W_WIDTH-1:0] width,
  input  logic [W_WIDTH-1:0] gap,
  input  logic [C_WIDTH-1:0] count,
`ifdef PULSE_GEN_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic               out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_e;

  state_e             state_q, state_d;
  logic [W_WIDTH-1:0] width_q, width_d;  // latched width, never 0
  logic [W_WIDTH-1:0] gap_q, gap_d;      // latched gap, never 0
  logic [W_WIDTH-1:0] phase_q, phase_d;  // cycles left in the current phase
  logic [C_WIDTH-1:0] rem_q, rem_d;      // pulses left, current one included
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               finish;            // burst ends at this edge
`ifdef PULSE_GEN_ABORT_EN
  logic               abort_hit;         // abort accepted at this edge
  logic               aborted_q, aborted_d;
`endif

  logic [W_WIDTH-1:0] width_eff, gap_eff;
  assign width_eff = (width == '0) ? W_WIDTH'(1) : width;
  assign gap_eff   = (gap   == '0) ? W_WIDTH'(1) : gap;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values from
    // before this edge; blocking here would create order-dependent races.
    if (rst) begin
      state_q   <= IDLE;
      width_q   <= '0;
      gap_q     <= '0;
      phase_q   <= '0;
      rem_q     <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PULSE_GEN_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      gap_q     <= gap_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PULSE_GEN_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // Next state: burst launch, phase countdown, pulse bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    width_d = width_q;
    gap_d   = gap_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    finish  = 1'b0;
`ifdef PULSE_GEN_ABORT_EN
    abort_hit = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          width_d = width_eff;
          gap_d   = gap_eff;
          rem_d   = count;
          if (count != '0) begin
            state_d = HIGH;
            phase_d = width_eff;
          end else begin
            finish = 1'b1;  // empty burst: done only
          end
        end
      end
      HIGH: begin
        phase_d = phase_q - W_WIDTH'(1);
        if (phase_q == W_WIDTH'(1)) begin
          rem_d = rem_q - C_WIDTH'(1);
          if (rem_q == C_WIDTH'(1)) begin
            state_d = IDLE;  // no gap after the final pulse
            finish  = 1'b1;
          end else begin
            state_d = GAP;
            phase_d = gap_q;
          end
        end
      end
      GAP: begin
        phase_d = phase_q - W_WIDTH'(1);
        if (phase_q == W_WIDTH'(1)) begin
          state_d = HIGH;
          phase_d = width_q;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PULSE_GEN_ABORT_EN
    // Abort overrides normal progress, but only while a burst is running.
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      phase_d   = '0;
      rem_d     = '0;
      finish    = 1'b1;
      abort_hit = 1'b1;
    end
`endif
  end

  // Outputs derived from the next state, registered in the state process.
  always_comb begin
    out_d     = (state_d == HIGH);
    busy_d    = (state_d != IDLE);
    done_d    = finish;
`ifdef PULSE_GEN_ABORT_EN
    aborted_d = abort_hit;
`endif
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef PULSE_GEN_ABORT_EN
  assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: directed scenarios plus a randomized run,
// all checked cycle by cycle against an arithmetic model of the burst timing.
module tb_pulse_train_generator;

  localparam int WW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WW-1:0] width;
  logic [WW-1:0] gap;
  logic [CW-1:0] count;
  logic          out;
  logic          busy;
  logic          done;
`ifdef PULSE_GEN_ABORT_EN
  logic          abort;
  logic          aborted;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: one burst described by its launch cycle and parameters.
  bit m_valid = 1'b0;
  int m_t0 = 0;
  int m_w = 1;
  int m_g = 1;
  int m_n = 0;
  int m_abort_cyc = -1;

  // Directed-test bookkeeping.
  int       first_done = -1;
  logic [2:0] hist = 3'b000;
  int       det_cnt = 0;

  always #5 clk = ~clk;

  pulse_train_generator #(.W_WIDTH(WW), .C_WIDTH(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .width  (width),
    .gap    (gap),
    .count  (count),
`ifdef PULSE_GEN_ABORT_EN
    .abort  (abort),
    .aborted(aborted),
`endif
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs for the current cycle, from the burst formula.
  function automatic void model_outputs(output bit e_out, output bit e_busy,
                                        output bit e_done, output bit e_abt);
    int r;
    int len;
    e_out = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_abt = 1'b0;
    if (m_abort_cyc == cyc) begin
      e_done = 1'b1;
      e_abt  = 1'b1;
    end else if (m_valid) begin
      r   = cyc - m_t0 + 1;
      len = m_n * m_w + ((m_n > 0) ? (m_n - 1) * m_g : 0);
      if (r >= 1 && r <= len) begin
        e_busy = 1'b1;
        e_out  = ((r - 1) % (m_w + m_g)) < m_w;
      end else if (r == len + 1) begin
        e_done = 1'b1;
      end
    end
  endfunction

  // Drive one cycle of inputs, advance one edge, update the model, check.
  task automatic step(input bit s, input int w, input int g, input int n,
                      input bit r, input bit a);
    bit eo, eb, ed, ea;
    start = s;
    width = w[WW-1:0];
    gap   = g[WW-1:0];
    count = n[CW-1:0];
    rst   = r;
`ifdef PULSE_GEN_ABORT_EN
    abort = a;
`endif
    model_outputs(eo, eb, ed, ea);  // busy as seen at the sampling edge
    @(posedge clk);
    cyc++;
    if (r) begin
      m_valid     = 1'b0;
      m_abort_cyc = -1;
    end else begin
`ifdef PULSE_GEN_ABORT_EN
      if (a && eb) begin
        m_valid     = 1'b0;
        m_abort_cyc = cyc;
      end else
`endif
      if (s && !eb) begin
        m_valid = 1'b1;
        m_t0    = cyc;
        m_w     = (w == 0) ? 1 : w;
        m_g     = (g == 0) ? 1 : g;
        m_n     = n;
      end
    end
    #1;
    model_outputs(eo, eb, ed, ea);
    check("out", 32'(out), 32'(eo));
    check("busy", 32'(busy), 32'(eb));
    check("done", 32'(done), 32'(ed));
`ifdef PULSE_GEN_ABORT_EN
    check("aborted", 32'(aborted), 32'(ea));
`endif
    if (done === 1'b1 && first_done < 0) first_done = cyc;
    hist = {hist[1:0], out};
    if (hist == 3'b010) det_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  int t0;

  initial begin
    start = 1'b0; width = '0; gap = '0; count = '0; rst = 1'b1;
`ifdef PULSE_GEN_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    idle(2);

    // Single-cycle pulses: done in cycle 4, detector fires twice.
    first_done = -1; det_cnt = 0; hist = 3'b000; t0 = cyc;
    step(1'b1, 1, 1, 2, 1'b0, 1'b0);
    idle(5);
    check("single_done_cycle", 32'(first_done - t0), 32'd4);
    check("single_010_count", 32'(det_cnt), 32'd2);

    // Wide pulse.
    first_done = -1; t0 = cyc;
    step(1'b1, 3, 2, 1, 1'b0, 1'b0);
    idle(5);
    check("wide_done_cycle", 32'(first_done - t0), 32'd4);

    // Empty burst and zero-field substitution.
    first_done = -1; t0 = cyc;
    step(1'b1, 5, 5, 0, 1'b0, 1'b0);
    idle(3);
    check("empty_done_cycle", 32'(first_done - t0), 32'd1);
    first_done = -1; t0 = cyc;
    step(1'b1, 0, 0, 3, 1'b0, 1'b0);
    idle(7);
    check("zero_done_cycle", 32'(first_done - t0), 32'd6);

    // Start held through the burst and into the done cycle.
    first_done = -1; t0 = cyc;
    for (int i = 0; i < 8; i++) step(1'b1, 2, 2, 2, 1'b0, 1'b0);
    check("hs_done_cycle", 32'(first_done - t0), 32'd7);
    check("hs_restart_out", 32'(out), 32'd1);
    idle(10);

    // Reset mid-burst, then a normal burst.
    first_done = -1;
    step(1'b1, 4, 4, 3, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(30);
    check("rst_no_done", 32'(first_done), 32'hFFFF_FFFF);
    first_done = -1; t0 = cyc;
    step(1'b1, 2, 1, 2, 1'b0, 1'b0);
    idle(8);
    check("post_rst_done_cycle", 32'(first_done - t0), 32'd6);

    // Abort in cycle 2 of a width=4 gap=1 count=2 burst.
    first_done = -1; t0 = cyc;
    step(1'b1, 4, 1, 2, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(12);
`ifdef PULSE_GEN_ABORT_EN
    check("abort_done_cycle", 32'(first_done - t0), 32'd3);
`else
    check("noabort_done_cycle", 32'(first_done - t0), 32'd10);
`endif

    // Randomized traffic with fields changing every cycle.
    for (int i = 0; i < 4000; i++) begin
      bit s, r, a;
      int w, g, n;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 299) == 0);
      a = ($urandom_range(0, 49) == 0);
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      g = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      n = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      step(s, w, g, n, r, a);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
